// File: rtl/proc_param_pkg.sv
// proc_param_pkg: opcodes, step encodings and bus selects for the multicycle processor
package proc_param_pkg;
  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVNZ = 3'd5;
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  typedef enum logic [3:0] {
    SEL_R0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_R7,
    SEL_DIN, SEL_G, SEL_NONE
  } sel_t;
endpackage

// File: rtl/proc_param_regn.sv
// regn: W-bit register with load enable and asynchronous active-low clear
module regn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor with shared bus, 8 GPRs, A/G and zero flag
module proc_param
  import proc_param_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] ZERO_BUS = '0
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  output logic         Done,
  output logic [W-1:0] Bus,
  output logic         Zflag
);
  step_t step, step_nxt;
  sel_t sel;
  logic [8:0] ir;
  logic [2:0] op, rx, ry;
  logic z, wr, a_en, g_en;
  logic [7:0] r_en;
  logic [W-1:0] r [8];
  logic [W-1:0] a, g, alu;
  assign {op, rx, ry} = ir;
  assign r_en = {7'b0, wr} << rx;
  assign alu = op == OP_ADD ? a + Bus : op == OP_SUB ? a - Bus : a & Bus;
  assign Bus = sel == SEL_DIN ? DIN : sel == SEL_G ? g : sel == SEL_NONE ? ZERO_BUS : r[sel[2:0]];
  assign Zflag = z;
  for (genvar i = 0; i < 8; i++) begin : g_r
    regn #(.W(W)) u_r (.clk(Clock), .rst_n(Resetn), .en(r_en[i]), .d(Bus), .q(r[i]));
  end
  regn #(.W(W)) u_a (.clk(Clock), .rst_n(Resetn), .en(a_en), .d(Bus), .q(a));
  regn #(.W(W)) u_g (.clk(Clock), .rst_n(Resetn), .en(g_en), .d(alu), .q(g));
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      step <= T0;
      ir   <= '0;
      z    <= 1'b0;
    end else begin
      step <= step_nxt;
      if (step == T0 && Run) ir <= DIN[8:0];
      if (g_en) z <= alu == '0;
    end
  // T2 is only reachable by ALU ops, so it needs no opcode decode
  always_comb begin
    sel      = SEL_NONE;
    wr       = 1'b0;
    a_en     = 1'b0;
    g_en     = 1'b0;
    Done     = 1'b0;
    step_nxt = step;
    case (step)
      T0: step_nxt = Run ? T1 : T0;
      T1:
        case (op)
          OP_MV: begin
            sel  = sel_t'({1'b0, ry});
            wr   = 1'b1;
            Done = 1'b1;
          end
          OP_MVI: begin
            sel  = SEL_DIN;
            wr   = 1'b1;
            Done = 1'b1;
          end
          OP_MVNZ: begin
            sel  = sel_t'({1'b0, ry});
            wr   = !z;
            Done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel      = sel_t'({1'b0, rx});
            a_en     = 1'b1;
            step_nxt = T2;
          end
          default: Done = 1'b1;
        endcase
      T2: begin
        sel      = sel_t'({1'b0, ry});
        g_en     = 1'b1;
        step_nxt = T3;
      end
      T3: begin
        sel  = SEL_G;
        wr   = 1'b1;
        Done = 1'b1;
      end
    endcase
    if (Done) step_nxt = T0;
  end
endmodule
